// File: rtl/arcade_font_pkg.sv
// Shared constants and types for the arcade glyph ROM text overlay.
// The glyph address packs an 8-bit character code above an 8-bit glyph row.
package arcade_font_pkg;

    localparam int GLYPH_W    = 40;
    localparam int GLYPH_H    = 40;
    localparam int ROM_ADDR_W = 16;
    localparam int CHAR_W     = 8;
    localparam int RGB_W      = 12;

    localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h00;

    typedef enum logic {
        PHASE_HIDDEN  = 1'b0,
        PHASE_VISIBLE = 1'b1
    } blink_phase_e;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic             hsync;
        logic             vsync;
        logic             de;
    } video_t;

    function automatic logic [ROM_ADDR_W-1:0] glyph_addr(input logic [CHAR_W-1:0] code,
                                                         input logic [5:0]        row);
        return {code, 2'b00, row};
    endfunction

endpackage

// File: rtl/arcade_text_buffer.sv
// Character slot register file with one write port and one async read port,
// plus the text length register clamped to the buffer depth.
module arcade_text_buffer
    import arcade_font_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        wr_idx,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              len_we,
    input  logic [4:0]        len_in,
    input  logic [3:0]        rd_idx,
    output logic [CHAR_W-1:0] rd_char,
    output logic [4:0]        text_len
);

    logic [CHAR_W-1:0] slot_q [MAX_CHARS];
    logic [CHAR_W-1:0] slot_d [MAX_CHARS];
    logic [4:0]        len_q;
    logic [4:0]        len_d;

    // Slots beyond MAX_CHARS simply never match, so out-of-range writes drop.
    always_comb begin
        for (int unsigned i = 0; i < MAX_CHARS; i++) begin
            slot_d[i] = slot_q[i];
            if (wr_en && wr_idx == 4'(i)) begin
                slot_d[i] = wr_char;
            end
        end
        len_d = len_q;
        if (len_we) begin
            len_d = (len_in > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : len_in;
        end
    end

    always_comb begin
        rd_char = BLANK_CHAR;
        for (int unsigned i = 0; i < MAX_CHARS; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_char = slot_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                slot_q[i] <= BLANK_CHAR;
            end
            len_q <= '0;
        end else begin
            for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            len_q <= len_d;
        end
    end

    assign text_len = len_q;

endmodule

// File: rtl/arcade_text_renderer.sv
// Scan-line text overlay: sequences glyph ROM addresses with pixel/char counters
// and merges glyph pixels over the game video with a fixed 3-clock latency.
module arcade_text_renderer
    import arcade_font_pkg::*;
#(
    parameter int unsigned      TEXT_X       = 200,
    parameter int unsigned      TEXT_Y       = 220,
    parameter int unsigned      MAX_CHARS    = 16,
    parameter int unsigned      BLINK_FRAMES = 30,
    parameter logic [RGB_W-1:0] FG_COLOR     = 12'hFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [10:0]           hcount,
    input  logic [10:0]           vcount,
    input  logic                  de,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [RGB_W-1:0]      rgb_in,
    input  logic                  wr_en,
    input  logic [3:0]            wr_idx,
    input  logic [CHAR_W-1:0]     wr_char,
    input  logic                  len_we,
    input  logic [4:0]            len_in,
    input  logic                  blink_en,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [GLYPH_W-1:0]    rom_data,
    output logic [RGB_W-1:0]      rgb_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  de_out
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CHAR_W-1:0] cur_char;
    logic [4:0]        text_len;

    video_t       vid_in;
    video_t       vid_a_q, vid_a_d;
    video_t       vid_b_q, vid_b_d;
    video_t       vid_c_q, vid_c_d;
    logic [5:0]   px_a_q, px_a_d;
    logic [3:0]   char_idx_q, char_idx_d;
    logic         in_box_a_q, in_box_a_d;
    logic [5:0]   glyph_row_q, glyph_row_d;
    logic [5:0]   px_b_q, px_b_d;
    logic         in_box_b_q, in_box_b_d;
    logic         vsync_prev_q, vsync_prev_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    blink_phase_e phase_q, phase_d;

    logic row_hit;
    logic run_start;
    logic last_px;
    logic last_char;
    logic frame_tick;
    logic [GLYPH_W-1:0] row_shifted;
    logic pixel_on;

    arcade_text_buffer #(
        .MAX_CHARS (MAX_CHARS)
    ) u_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_char  (wr_char),
        .len_we   (len_we),
        .len_in   (len_in),
        .rd_idx   (char_idx_q),
        .rd_char  (cur_char),
        .text_len (text_len)
    );

    assign vid_in = '{rgb: rgb_in, hsync: hsync_in, vsync: vsync_in, de: de};

    // Stage A: run control. Counters replace any divide of hcount by GLYPH_W.
    always_comb begin
        row_hit     = (vcount >= 11'(TEXT_Y)) && (vcount <= 11'(TEXT_Y + GLYPH_H - 1));
        glyph_row_d = 6'(vcount - 11'(TEXT_Y));
        run_start   = de && row_hit && (hcount == 11'(TEXT_X)) && (text_len != '0);
        last_px     = (px_a_q == 6'(GLYPH_W - 1));
        last_char   = ({1'b0, char_idx_q} + 5'd1) >= text_len;

        px_a_d      = px_a_q;
        char_idx_d  = char_idx_q;
        in_box_a_d  = in_box_a_q;
        vid_a_d     = vid_in;

        if (run_start) begin
            px_a_d     = '0;
            char_idx_d = '0;
            in_box_a_d = 1'b1;
        end else if (!de) begin
            in_box_a_d = 1'b0;
        end else if (in_box_a_q) begin
            if (last_px) begin
                px_a_d = '0;
                if (last_char) begin
                    in_box_a_d = 1'b0;
                end else begin
                    char_idx_d = char_idx_q + 4'd1;
                end
            end else begin
                px_a_d = px_a_q + 6'd1;
            end
        end
    end

    assign rom_addr = in_box_a_q ? glyph_addr(cur_char, glyph_row_q) : '0;

    // Stage B travels alongside the ROM's own read register.
    always_comb begin
        px_b_d     = px_a_q;
        in_box_b_d = in_box_a_q;
        vid_b_d    = vid_a_q;
    end

    // Shifting the row word left by px lands the selected pixel at the MSB.
    always_comb begin
        row_shifted = rom_data << px_b_q;
        pixel_on    = in_box_b_q && row_shifted[GLYPH_W-1] && (phase_q == PHASE_VISIBLE);
        vid_c_d     = vid_b_q;
        if (pixel_on) begin
            vid_c_d.rgb = FG_COLOR;
        end
    end

    always_comb begin
        frame_tick   = vsync_in && !vsync_prev_q;
        vsync_prev_d = vsync_in;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            phase_d     = PHASE_VISIBLE;
        end else if (frame_tick) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_a_q      <= '0;
            px_a_q       <= '0;
            char_idx_q   <= '0;
            in_box_a_q   <= 1'b0;
            glyph_row_q  <= '0;
            vid_b_q      <= '0;
            px_b_q       <= '0;
            in_box_b_q   <= 1'b0;
            vid_c_q      <= '0;
            vsync_prev_q <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= PHASE_VISIBLE;
        end else begin
            vid_a_q      <= vid_a_d;
            px_a_q       <= px_a_d;
            char_idx_q   <= char_idx_d;
            in_box_a_q   <= in_box_a_d;
            glyph_row_q  <= glyph_row_d;
            vid_b_q      <= vid_b_d;
            px_b_q       <= px_b_d;
            in_box_b_q   <= in_box_b_d;
            vid_c_q      <= vid_c_d;
            vsync_prev_q <= vsync_prev_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign rgb_out   = vid_c_q.rgb;
    assign hsync_out = vid_c_q.hsync;
    assign vsync_out = vid_c_q.vsync;
    assign de_out    = vid_c_q.de;

endmodule

// File: tb/tb_arcade_text_renderer.sv
// Directed bench for arcade_text_renderer: drives pixel streams, models the glyph
// ROM, and checks every output 3 steps (rom_addr 1 step) after the driving input.
module tb_arcade_text_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount, vcount;
    logic        de, hsync_in, vsync_in;
    logic [11:0] rgb_in;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_char;
    logic        len_we;
    logic [4:0]  len_in;
    logic        blink_en;
    logic [15:0] rom_addr;
    logic [39:0] rom_data;
    logic [11:0] rgb_out;
    logic        hsync_out, vsync_out, de_out;

    always #5 clk = ~clk;

    arcade_text_renderer #(
        .TEXT_X       (200),
        .TEXT_Y       (220),
        .MAX_CHARS    (16),
        .BLINK_FRAMES (2),
        .FG_COLOR     (12'hFFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .de        (de),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .rgb_in    (rgb_in),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_char   (wr_char),
        .len_we    (len_we),
        .len_in    (len_in),
        .blink_en  (blink_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rgb_out   (rgb_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .de_out    (de_out)
    );

    // Glyph 0x47: row 0 lit at px 10..29, row 15 lit at px 0..9 and 20..34.
    function automatic logic [39:0] rom_word(input logic [15:0] a);
        case (a)
            16'h4700: return 40'h003FFFFC00;
            16'h470F: return 40'hFFC00FFFE0;
            default:  return '0;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;

    exp_t        pipe [3];
    logic [15:0] addr_prev;
    logic [7:0]  m_buf [16];
    int          m_len;
    logic        m_vis;
    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_tag  = "init";

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s %s: got %h expected %h", cur_tag, name, got, exp);
        end
    endtask

    task automatic check_zero();
        check("rgb_out", 16'(rgb_out), 16'h0);
        check("hsync_out", 16'(hsync_out), 16'h0);
        check("vsync_out", 16'(vsync_out), 16'h0);
        check("de_out", 16'(de_out), 16'h0);
        check("rom_addr", rom_addr, 16'h0);
    endtask

    task automatic clear_expect();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        addr_prev = '0;
    endtask

    task automatic step(input int h, input int v, input logic d, input logic hs, input logic vs);
        logic [11:0] rgb;
        logic [15:0] addr;
        logic [39:0] word;
        logic        on;
        int          col;
        int          px;
        check("rgb_out", 16'(rgb_out), 16'(pipe[2].rgb));
        check("hsync_out", 16'(hsync_out), 16'(pipe[2].hs));
        check("vsync_out", 16'(vsync_out), 16'(pipe[2].vs));
        check("de_out", 16'(de_out), 16'(pipe[2].de));
        check("rom_addr", rom_addr, addr_prev);
        rgb  = 12'(h * 37 + v * 11);
        addr = '0;
        on   = 1'b0;
        if (d && v >= 220 && v <= 259 && m_len != 0 && h >= 200 && h < 200 + 40 * m_len) begin
            col  = h - 200;
            px   = col % 40;
            addr = {m_buf[col / 40], 8'(v - 220)};
            word = rom_word(addr);
            on   = word[39 - px] && m_vis;
        end
        hcount   = 11'(h);
        vcount   = 11'(v);
        de       = d;
        hsync_in = hs;
        vsync_in = vs;
        rgb_in   = rgb;
        pipe[2]  = pipe[1];
        pipe[1]  = pipe[0];
        pipe[0]  = '{rgb: (on ? 12'hFFF : rgb), hs: hs, vs: vs, de: d};
        addr_prev = addr;
        @(negedge clk);
    endtask

    task automatic scan_line(input int v, input int h0, input int h1, input int de_end);
        for (int h = h0; h <= h1; h++) begin
            step(h, v, h < de_end, (h >= 656 && h < 752), 1'b0);
        end
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 4; i++) step(0, 490, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(0, 490, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_slot(input int idx, input logic [7:0] code);
        wr_en   = 1'b1;
        wr_idx  = 4'(idx);
        wr_char = code;
        step(0, 0, 1'b0, 1'b0, 1'b0);
        wr_en = 1'b0;
        m_buf[idx] = code;
    endtask

    task automatic write_len(input int len);
        len_we = 1'b1;
        len_in = 5'(len);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        len_we = 1'b0;
        m_len  = (len > 16) ? 16 : len;
    endtask

    initial begin
        rst_n = 1'b0; hcount = '0; vcount = '0; de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        rgb_in = '0; wr_en = 1'b0; wr_idx = '0; wr_char = '0; len_we = 1'b0; len_in = '0;
        blink_en = 1'b0;
        for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
        m_len = 0;
        m_vis = 1'b1;
        clear_expect();
        repeat (3) @(negedge clk);
        cur_tag = "reset_state";
        check_zero();
        rst_n = 1'b1;

        // Single glyph on row 0 and row 15.
        cur_tag = "row0";
        write_slot(0, 8'h47);
        write_len(1);
        scan_line(220, 190, 250, 640);
        cur_tag = "row15";
        scan_line(235, 190, 250, 640);

        // Reset asserted mid-run at hcount 215.
        cur_tag = "reset_midline";
        scan_line(220, 190, 215, 640);
        rst_n = 1'b0;
        #1;
        check_zero();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_zero();
            hcount = 11'(216 + i);
            rgb_in = 12'(i * 300 + 7);
        end
        @(negedge clk);
        check_zero();
        for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
        m_len = 0;
        m_vis = 1'b1;
        clear_expect();
        rst_n = 1'b1;
        cur_tag = "post_reset_len0";
        scan_line(220, 0, 260, 640);
        cur_tag = "post_reset_blank";
        write_len(1);
        scan_line(235, 190, 250, 640);

        // Full buffer, oversized length clamped to 16.
        cur_tag = "full_wide_de";
        for (int i = 0; i < 16; i++) write_slot(i, 8'h47);
        write_len(20);
        scan_line(220, 190, 860, 1000);
        cur_tag = "full_trunc_de";
        scan_line(220, 190, 700, 640);

        // Length 0: pure pass-through.
        cur_tag = "len0_frame";
        write_len(0);
        scan_line(219, 0, 799, 640);
        scan_line(220, 0, 799, 640);
        scan_line(240, 0, 799, 640);
        vsync_pulse();
        scan_line(0, 0, 799, 640);

        // Blinking with a 2-frame phase.
        cur_tag = "blink";
        write_len(1);
        blink_en = 1'b1;
        scan_line(220, 190, 250, 640);
        vsync_pulse();
        scan_line(220, 190, 250, 640);
        vsync_pulse();
        m_vis = 1'b0;
        cur_tag = "blink_hidden";
        scan_line(220, 190, 250, 640);
        vsync_pulse();
        scan_line(220, 190, 250, 640);
        vsync_pulse();
        m_vis = 1'b1;
        cur_tag = "blink_visible";
        scan_line(220, 190, 250, 640);
        vsync_pulse();
        vsync_pulse();
        m_vis = 1'b0;
        cur_tag = "blink_hidden2";
        scan_line(220, 190, 250, 640);
        blink_en = 1'b0;
        m_vis = 1'b1;
        cur_tag = "blink_off";
        scan_line(220, 190, 250, 640);

        cur_tag = "drain";
        for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
